hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REDIRECT_SQUASH, default 1: extra cycles q1q2 is flushed after a redirect, to cover instrmem read latency; legal range 1..3.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rs1_q2_ip, rs2_q2_ip  input  5 each  source registers of the instruction in decode.
REQ-006 uses_rs1_q2_ip, uses_rs2_q2_ip  input  1 each  the decode instruction reads rs1/rs2.
REQ-007 rd_q3_ip  input  5  destination of the instruction in execute.
REQ-008 mem_ren_q3_ip, reg_wr_en_q3_ip  input  1 each  the execute instruction is a load / writes a register.
REQ-009 branch_taken_q4_ip  input  1  the q4 instruction redirects the PC.
REQ-010 mem_busy_ip  input  1  data memory cannot complete this cycle.
REQ-011 pc_wren_op, q1q2_wren_op, q2q3_wren_op, q3q4_wren_op, q4q5_wren_op  output  1 each  PC and pipeline-register load enables.
REQ-012 q1q2_flush_op, q2q3_flush_op, q3q4_flush_op, q4q5_flush_op  output  1 each  load a bubble (instr=NOP, ctrl=0) instead of the upstream value.
REQ-013 pc_redirect_op  output  1  PC loads the redirect target instead of pc+4.
REQ-014 stall_cycles_op, flush_count_op  output  CNT_WIDTH each  performance counters.

Function
REQ-015 FSM states SHALL be RUN, LOAD_STALL and SQUASH, plus a squash counter of width clog2(REDIRECT_SQUASH+1).
REQ-016 Default outputs: every wren=1, every flush=0, pc_redirect_op=0.
REQ-017 load_use = mem_ren_q3_ip & reg_wr_en_q3_ip & (rd_q3_ip!=0) & ((uses_rs1_q2_ip & rs1_q2_ip==rd_q3_ip) | (uses_rs2_q2_ip & rs2_q2_ip==rd_q3_ip)).
REQ-018 Priority, highest first: mem_busy_ip, then branch_taken_q4_ip, then the current state's action, then load_use.
REQ-019 When mem_busy_ip=1: all wren=0, q4q5_flush_op=1, all other flushes=0, pc_redirect_op=0; FSM state and squash counter hold; branch_taken_q4_ip is ignored, because the branch stays frozen in q4 and is acted on once busy drops.
REQ-020 When branch_taken_q4_ip=1 and not busy, in any state:
- pc_redirect_op=1;
- q1q2_flush_op=1, q2q3_flush_op=1, q3q4_flush_op=1;
- next state SQUASH, squash counter loaded with REDIRECT_SQUASH.
REQ-021 SQUASH: q1q2_flush_op=1. The counter decrements each cycle; the FSM returns to RUN in the cycle the counter reaches 1. load_use SHALL be ignored while in SQUASH.
REQ-022 RUN with load_use: pc_wren_op=0, q1q2_wren_op=0, q2q3_flush_op=1; next state LOAD_STALL.
REQ-023 LOAD_STALL: the same outputs as REQ-022 regardless of load_use; next state RUN. This gives exactly two bubbles, so the load data reaches q5 for forwarding.
REQ-024 A new load_use in the first RUN cycle after LOAD_STALL SHALL start a fresh two-cycle stall.

Reset
REQ-025 While rst=1, the unit SHALL drive:
- state=RUN, squash counter=0, both counters=0;
- every wren=1, every flush=1, pc_redirect_op=0.
REQ-026 rst asserted mid-stall or mid-squash SHALL abandon that stall or squash; the first cycle after rst deasserts is RUN.

Configuration
REQ-027 Macro HAZARD_UNIT_PERF_EN defined: the unit SHALL implement both counters as follows.
- stall_cycles_op increments in each cycle with pc_wren_op=0.
- flush_count_op increments on each accepted branch_taken_q4_ip.
- Both counters saturate at all-ones.
REQ-028 Macro undefined: the counter ports SHALL remain, tied to 0, with no counter flops.

Structure
REQ-029 The FSM state enum and the NOP encoding (32'h00000013) SHALL live in a shared package cpu_pkg.
REQ-030 There SHALL be no sub-modules; the unit is a single module.

Verification
REQ-031 Load-use: lw x1 in q3, add x2,x1,x3 in q2 -> pc_wren_op=0 for exactly 2 cycles, q2q3_flush_op=1 both cycles, then RUN.
REQ-032 rd=x0: load with rd_q3_ip=0 and rs1_q2_ip=0 -> no stall.
REQ-033 Branch with REDIRECT_SQUASH=2: pulse branch_taken_q4_ip -> cycle 0 flushes q1q2/q2q3/q3q4 with pc_redirect_op=1, then 2 cycles of q1q2_flush_op only.
REQ-034 Branch during LOAD_STALL: taken in the second stall cycle -> branch action wins, state SQUASH, no further stall.
REQ-035 mem_busy_ip held 3 cycles during SQUASH with branch_taken_q4_ip=1 -> all wren=0 and q4q5_flush_op=1 for 3 cycles, then the redirect fires once.
REQ-036 With HAZARD_UNIT_PERF_EN, after REQ-031 and REQ-033 -> stall_cycles_op=2, flush_count_op=1; rst mid-sequence clears both.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared across the CPU pipeline blocks.
//   hz_state_e : hazard unit FSM states
//   NOP_INSTR  : instruction word used for pipeline bubbles (addi x0,x0,0)
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    SQUASH     = 2'd2
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard control for the 5-stage core.
//   Detects load-use hazards (two-bubble stall), applies branch redirects
//   with a configurable q1q2 squash tail, and freezes the pipe while the
//   data memory is busy.
// Parameters:
//   REDIRECT_SQUASH : extra q1q2 flush cycles after a redirect (1..3)
//   CNT_WIDTH       : width of the performance counters
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   rs1_q2_ip/rs2_q2_ip, uses_*    : decode-stage source operands
//   rd_q3_ip, mem_ren_q3_ip,
//   reg_wr_en_q3_ip                : execute-stage destination / kind
//   branch_taken_q4_ip             : q4 redirects the PC
//   mem_busy_ip                    : data memory stall
//   *_wren_op, *_flush_op          : PC / pipeline register control
//   pc_redirect_op                 : PC takes the redirect target
//   stall_cycles_op, flush_count_op: performance counters
// Build option:
//   HAZARD_UNIT_PERF_EN : implement the saturating performance counters;
//                         when undefined the counter ports read as zero.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int REDIRECT_SQUASH = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_q2_ip,
  input  logic [4:0]           rs2_q2_ip,
  input  logic                 uses_rs1_q2_ip,
  input  logic                 uses_rs2_q2_ip,
  input  logic [4:0]           rd_q3_ip,
  input  logic                 mem_ren_q3_ip,
  input  logic                 reg_wr_en_q3_ip,
  input  logic                 branch_taken_q4_ip,
  input  logic                 mem_busy_ip,
  output logic                 pc_wren_op,
  output logic                 q1q2_wren_op,
  output logic                 q2q3_wren_op,
  output logic                 q3q4_wren_op,
  output logic                 q4q5_wren_op,
  output logic                 q1q2_flush_op,
  output logic                 q2q3_flush_op,
  output logic                 q3q4_flush_op,
  output logic                 q4q5_flush_op,
  output logic                 pc_redirect_op,
  output logic [CNT_WIDTH-1:0] stall_cycles_op,
  output logic [CNT_WIDTH-1:0] flush_count_op
);

  localparam int SQW = $clog2(REDIRECT_SQUASH + 1);

  hz_state_e      state_q, state_d;
  logic [SQW-1:0] sq_cnt_q, sq_cnt_d;
  logic           load_use;
  logic           br_accept;

  assign load_use = mem_ren_q3_ip & reg_wr_en_q3_ip & (rd_q3_ip != 5'd0) &
                    ((uses_rs1_q2_ip & (rs1_q2_ip == rd_q3_ip)) |
                     (uses_rs2_q2_ip & (rs2_q2_ip == rd_q3_ip)));

  // A branch held in q4 while memory is busy is only acted on once busy drops.
  assign br_accept = ~rst & ~mem_busy_ip & branch_taken_q4_ip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      sq_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sq_cnt_d       = sq_cnt_q;
    pc_wren_op     = 1'b1;
    q1q2_wren_op   = 1'b1;
    q2q3_wren_op   = 1'b1;
    q3q4_wren_op   = 1'b1;
    q4q5_wren_op   = 1'b1;
    q1q2_flush_op  = 1'b0;
    q2q3_flush_op  = 1'b0;
    q3q4_flush_op  = 1'b0;
    q4q5_flush_op  = 1'b0;
    pc_redirect_op = 1'b0;
    if (rst) begin
      // Load bubbles everywhere so the pipe comes out of reset clean.
      q1q2_flush_op = 1'b1;
      q2q3_flush_op = 1'b1;
      q3q4_flush_op = 1'b1;
      q4q5_flush_op = 1'b1;
    end else if (mem_busy_ip) begin
      // Freeze everything; q4q5 gets a bubble since q4 cannot retire.
      pc_wren_op    = 1'b0;
      q1q2_wren_op  = 1'b0;
      q2q3_wren_op  = 1'b0;
      q3q4_wren_op  = 1'b0;
      q4q5_wren_op  = 1'b0;
      q4q5_flush_op = 1'b1;
    end else if (branch_taken_q4_ip) begin
      pc_redirect_op = 1'b1;
      q1q2_flush_op  = 1'b1;
      q2q3_flush_op  = 1'b1;
      q3q4_flush_op  = 1'b1;
      state_d        = SQUASH;
      sq_cnt_d       = SQW'(REDIRECT_SQUASH);
    end else begin
      unique case (state_q)
        SQUASH: begin
          // Covers instruction memory latency after the redirect.
          q1q2_flush_op = 1'b1;
          sq_cnt_d      = sq_cnt_q - 1'b1;
          if (sq_cnt_q <= SQW'(1)) state_d = RUN;
        end
        LOAD_STALL: begin
          pc_wren_op    = 1'b0;
          q1q2_wren_op  = 1'b0;
          q2q3_flush_op = 1'b1;
          state_d       = RUN;
        end
        default: begin
          if (load_use) begin
            pc_wren_op    = 1'b0;
            q1q2_wren_op  = 1'b0;
            q2q3_flush_op = 1'b1;
            state_d       = LOAD_STALL;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_UNIT_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_wren_op && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (br_accept && (flush_q != '1))   flush_q <= flush_q + 1'b1;
    end
  end

  // Counters read zero for the whole reset window, not just after the edge.
  assign stall_cycles_op = rst ? '0 : stall_q;
  assign flush_count_op  = rst ? '0 : flush_q;
`else
  logic unused_br;
  assign unused_br       = br_accept;
  assign stall_cycles_op = '0;
  assign flush_count_op  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int RS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          u1, u2, mren, wen, br, busy;
  logic          pc_wren, q1q2_wren, q2q3_wren, q3q4_wren, q4q5_wren;
  logic          q1q2_fl, q2q3_fl, q3q4_fl, q4q5_fl, redir;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining stall / squash cycles, counters.
  int m_stall_left, m_squash_left, m_stalls, m_flushes;

  hazard_unit #(.REDIRECT_SQUASH(RS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_q2_ip(rs1), .rs2_q2_ip(rs2),
    .uses_rs1_q2_ip(u1), .uses_rs2_q2_ip(u2),
    .rd_q3_ip(rd), .mem_ren_q3_ip(mren), .reg_wr_en_q3_ip(wen),
    .branch_taken_q4_ip(br), .mem_busy_ip(busy),
    .pc_wren_op(pc_wren), .q1q2_wren_op(q1q2_wren), .q2q3_wren_op(q2q3_wren),
    .q3q4_wren_op(q3q4_wren), .q4q5_wren_op(q4q5_wren),
    .q1q2_flush_op(q1q2_fl), .q2q3_flush_op(q2q3_fl),
    .q3q4_flush_op(q3q4_fl), .q4q5_flush_op(q4q5_fl),
    .pc_redirect_op(redir),
    .stall_cycles_op(stall_cnt), .flush_count_op(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs packed as {pc,q1q2,q2q3,q3q4,q4q5 wren, q1q2,q2q3,q3q4,q4q5 flush, redirect}
  function automatic logic [9:0] pack(input logic [4:0] w, input logic [3:0] f, input logic r);
    return {w, f, r};
  endfunction

  // One cycle: inputs already set; compare, then advance the model at the edge.
  task automatic step();
    logic [9:0] exp_o;
    logic       lu;
    int         exp_s, exp_f;
    bit         stall_now, br_now;
    #1;
    lu = mren && wen && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    stall_now = 0;
    br_now    = 0;
    if (rst)                 exp_o = pack(5'b11111, 4'b1111, 1'b0);
    else if (busy)           exp_o = pack(5'b00000, 4'b0001, 1'b0);
    else if (br) begin       exp_o = pack(5'b11111, 4'b1110, 1'b1); br_now = 1; end
    else if (m_squash_left > 0) exp_o = pack(5'b11111, 4'b1000, 1'b0);
    else if (m_stall_left > 0 || lu) begin
      exp_o = pack(5'b00111, 4'b0100, 1'b0); stall_now = 1;
    end else                 exp_o = pack(5'b11111, 4'b0000, 1'b0);
`ifdef HAZARD_UNIT_PERF_EN
    exp_s = rst ? 0 : m_stalls;
    exp_f = rst ? 0 : m_flushes;
`else
    exp_s = 0;
    exp_f = 0;
`endif
    chk("ctrl", 32'(pack({pc_wren, q1q2_wren, q2q3_wren, q3q4_wren, q4q5_wren},
                         {q1q2_fl, q2q3_fl, q3q4_fl, q4q5_fl}, redir)), 32'(exp_o));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_s));
    chk("flush_cnt", 32'(flush_cnt), 32'(exp_f));
    @(posedge clk);
    if (rst) begin
      m_stall_left = 0; m_squash_left = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!exp_o[9] && m_stalls < 255) m_stalls++;
      if (busy) ;
      else if (br_now) begin
        m_squash_left = RS; m_stall_left = 0;
        if (m_flushes < 255) m_flushes++;
      end else if (m_squash_left > 0) m_squash_left--;
      else if (stall_now) m_stall_left = (m_stall_left > 0) ? 0 : 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0;
    mren = 0; wen = 0; br = 0; busy = 0;
  endtask

  // lw x1 in q3 with add x2,x1,x3 in q2
  task automatic load_use_x1();
    idle(); rd = 5'd1; mren = 1; wen = 1; rs1 = 5'd1; rs2 = 5'd3; u1 = 1; u2 = 1;
  endtask

  initial begin
    m_stall_left = 0; m_squash_left = 0; m_stalls = 0; m_flushes = 0;
    idle(); rst = 1;
    @(negedge clk);
    step(); step();
    idle(); step();

    // Load-use: two stall cycles, then RUN
    load_use_x1(); step();
    idle(); step();
    step();
    // x0 destination never stalls
    idle(); mren = 1; wen = 1; rd = 0; rs1 = 0; u1 = 1; step();
    idle(); step();
    // Taken branch: redirect cycle, then RS cycles of q1q2 flush
    br = 1; step();
    br = 0; step(); step(); step();
`ifdef HAZARD_UNIT_PERF_EN
    chk("perf_stall", 32'(stall_cnt), 32'd2);
    chk("perf_flush", 32'(flush_cnt), 32'd1);
`else
    chk("perf_stall", 32'(stall_cnt), 32'd0);
    chk("perf_flush", 32'(flush_cnt), 32'd0);
`endif
    // Branch in second stall cycle wins
    load_use_x1(); step();
    idle(); br = 1; step();
    br = 0; step(); step(); step();
    // Busy held 3 cycles during SQUASH with a pending branch
    br = 1; step();
    busy = 1; step(); step(); step();
    busy = 0; step();
    br = 0; step(); step(); step();
    // Back-to-back load-use restarts a fresh stall
    load_use_x1(); step(); step(); step(); step();
    idle(); step();
    // Reset mid-stall and mid-squash
    load_use_x1(); step();
    rst = 1; step();
    idle(); step(); step();
    br = 1; step();
    br = 0; rst = 1; step();
    idle(); step();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom_range(0, 99) < 1);
      busy = ($urandom_range(0, 99) < 12);
      br   = ($urandom_range(0, 99) < 8);
      mren = ($urandom_range(0, 99) < 60);
      wen  = ($urandom_range(0, 99) < 80);
      rd   = 5'($urandom_range(0, 3));
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      u1   = 1'($urandom);
      u2   = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
